// File: rtl/sobel_window_gradient_if.sv
// Pixel-in / gradient-out bundle for the Sobel window front end.
//   master : pixel source (drives pixel_in/pixel_valid/frame_start,
//            observes the gradient outputs)
//   slave  : the Sobel block (consumes pixels, produces gx/gy/valid/last)
interface sobel_window_gradient_if;
  logic        [7:0]  pixel_in;
  logic               pixel_valid;
  logic               frame_start;
  logic signed [10:0] gx_out;
  logic signed [10:0] gy_out;
  logic               grad_valid;
  logic               grad_last;

  modport master (
    output pixel_in, pixel_valid, frame_start,
    input  gx_out, gy_out, grad_valid, grad_last
  );

  modport slave (
    input  pixel_in, pixel_valid, frame_start,
    output gx_out, gy_out, grad_valid, grad_last
  );
endinterface

// File: rtl/sobel_window_gradient.sv
// Streaming Sobel front end.
// Accepts a raster-order 8-bit grayscale stream, builds a 3x3 window from two
// line buffers plus a column shift register, and emits signed 11-bit
// horizontal (gx) and vertical (gy) gradients two clocks after the pixel that
// completes each window is accepted.
// Ports:
//   clk    - single rising-edge clock
//   n_rst  - asynchronous active-low reset (clears counters, window, pipeline
//            and outputs; line-buffer RAM is left as is)
//   bus    - slave side of sobel_window_gradient_if:
//              pixel_in/pixel_valid/frame_start in,
//              gx_out/gy_out/grad_valid/grad_last out
module sobel_window_gradient #(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64
) (
  input  logic                    clk,
  input  logic                    n_rst,
  sobel_window_gradient_if.slave  bus
);

  localparam int CW     = (IMG_WIDTH  > 2) ? $clog2(IMG_WIDTH)  : 2;
  localparam int RW     = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 2;
  localparam int STAGES = 2;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  // Weighted column/row sum a + 2b + c; max 1020 fits 10 bits.
  function automatic logic [9:0] wsum(input logic [7:0] a,
                                      input logic [7:0] b,
                                      input logic [7:0] c);
    return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CW-1:0]            col_q, col_d;
  logic [RW-1:0]            row_q, row_d;
  logic [2:0][2:0][7:0]     win_q, win_d;      // win[r][c], r0=top, c0=left
  logic [STAGES:0]          vld_pipe_q, vld_pipe_d;
  logic [STAGES:0]          last_pipe_q, last_pipe_d;
  logic [9:0]               sxp_q, sxp_d;      // right column weighted sum
  logic [9:0]               sxn_q, sxn_d;      // left column weighted sum
  logic [9:0]               syp_q, syp_d;      // bottom row weighted sum
  logic [9:0]               syn_q, syn_d;      // top row weighted sum
  logic signed [10:0]       gx_q, gx_d;
  logic signed [10:0]       gy_q, gy_d;

  logic [7:0]               lb0 [IMG_WIDTH];   // previous row
  logic [7:0]               lb1 [IMG_WIDTH];   // row before that

  // ---------------------------------------------------------------------------
  // Input stage: position tracking, line-buffer read, window shift
  // ---------------------------------------------------------------------------
  logic          accept;
  logic [CW-1:0] col_cur;
  logic [RW-1:0] row_cur;
  logic [7:0]    top_pix, mid_pix;

  always_comb begin
    accept  = bus.pixel_valid;
    // frame_start forces this pixel to (0,0); it only matters on accept.
    col_cur = bus.frame_start ? '0 : col_q;
    row_cur = bus.frame_start ? '0 : row_q;
    top_pix = lb1[col_cur];
    mid_pix = lb0[col_cur];

    col_d = col_q;
    row_d = row_q;
    win_d = win_q;
    if (accept) begin
      if (col_cur == COL_LAST) begin
        col_d = '0;
        row_d = (row_cur == ROW_LAST) ? '0 : row_cur + RW'(1);
      end else begin
        col_d = col_cur + CW'(1);
        row_d = row_cur;
      end
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = top_pix;
      win_d[1][2] = mid_pix;
      win_d[2][2] = bus.pixel_in;
    end
  end

  // Line buffers are plain RAM: rows 0 and 1 of each frame overwrite them
  // before any window reads them, so no reset is needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[col_cur] <= lb0[col_cur];
      lb0[col_cur] <= bus.pixel_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Valid/last pipeline and arithmetic
  // ---------------------------------------------------------------------------
  always_comb begin
    vld_pipe_d     = {vld_pipe_q[STAGES-1:0], 1'b0};
    last_pipe_d    = {last_pipe_q[STAGES-1:0], 1'b0};
    // A window exists only once two full rows and two columns precede it.
    vld_pipe_d[0]  = accept && (row_cur >= ROW_TWO) && (col_cur >= COL_TWO);
    last_pipe_d[0] = accept && (row_cur == ROW_LAST) && (col_cur == COL_LAST);

    sxp_d = sxp_q;
    sxn_d = sxn_q;
    syp_d = syp_q;
    syn_d = syn_q;
    if (vld_pipe_q[0]) begin
      sxp_d = wsum(win_q[0][2], win_q[1][2], win_q[2][2]);
      sxn_d = wsum(win_q[0][0], win_q[1][0], win_q[2][0]);
      syp_d = wsum(win_q[2][0], win_q[2][1], win_q[2][2]);
      syn_d = wsum(win_q[0][0], win_q[0][1], win_q[0][2]);
    end

    // Outputs hold their last value between valid windows.
    gx_d = gx_q;
    gy_d = gy_q;
    if (vld_pipe_q[1]) begin
      gx_d = $signed({1'b0, sxp_q} - {1'b0, sxn_q});
      gy_d = $signed({1'b0, syp_q} - {1'b0, syn_q});
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      col_q       <= '0;
      row_q       <= '0;
      win_q       <= '0;
      vld_pipe_q  <= '0;
      last_pipe_q <= '0;
      sxp_q       <= '0;
      sxn_q       <= '0;
      syp_q       <= '0;
      syn_q       <= '0;
      gx_q        <= '0;
      gy_q        <= '0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      win_q       <= win_d;
      vld_pipe_q  <= vld_pipe_d;
      last_pipe_q <= last_pipe_d;
      sxp_q       <= sxp_d;
      sxn_q       <= sxn_d;
      syp_q       <= syp_d;
      syn_q       <= syn_d;
      gx_q        <= gx_d;
      gy_q        <= gy_d;
    end
  end

  assign bus.gx_out     = gx_q;
  assign bus.gy_out     = gy_q;
  assign bus.grad_valid = vld_pipe_q[STAGES];
  assign bus.grad_last  = last_pipe_q[STAGES];

endmodule
